// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam logic [3:0] COL_C1 = 4'b0111;
    localparam logic [3:0] COL_C2 = 4'b1011;
    localparam logic [3:0] COL_C3 = 4'b1101;
    localparam logic [3:0] COL_C4 = 4'b1110;

    // KEY_MAP[column][row], column 0 = C1, row 0 = R1
    localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
        '{4'h1, 4'h4, 4'h7, 4'h0},
        '{4'h2, 4'h5, 4'h8, 4'hF},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

    typedef enum logic [1:0] {
        DB_NONE    = 2'd0,
        DB_KEY     = 2'd1,
        DB_INVALID = 2'd2
    } db_state_e;

    typedef struct packed {
        db_state_e  kind;
        logic [3:0] code;
    } scan_res_t;

    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        logic [3:0] s;
        case (idx)
            2'd0:    s = COL_C1;
            2'd1:    s = COL_C2;
            2'd2:    s = COL_C3;
            default: s = COL_C4;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounces one scan result per strobe; commits after DEBOUNCE_SCANS
// identical scans and flags a press event on entry to a new key.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_vld_i,
    input  scan_res_t  scan_res_i,
    output db_state_e  state_o,
    output logic       key_held_o,
    output logic       event_o,
    output logic [3:0] event_code_o
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS);

    scan_res_t  cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    db_state_e  state_q;
    logic [3:0] code_q;
    logic       held_q;
    logic       commit;

    always_comb begin
        cand_d = scan_res_i;
        cnt_d  = 4'd1;
        if (scan_res_i == cand_q) begin
            cand_d = cand_q;
            cnt_d  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
        end
        commit       = scan_vld_i && (cnt_d == CNT_MAX);
        // Event only on entering a key different from the committed one.
        event_o      = commit && (cand_d.kind == DB_KEY) &&
                       ((state_q != DB_KEY) || (code_q != cand_d.code));
        event_code_o = cand_d.code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q  <= '{kind: DB_NONE, code: 4'h0};
            cnt_q   <= '0;
            state_q <= DB_NONE;
            code_q  <= '0;
            held_q  <= 1'b0;
        end else if (scan_vld_i) begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            if (commit) begin
                state_q <= cand_d.kind;
                code_q  <= cand_d.code;
                held_q  <= (cand_d.kind == DB_KEY);
            end
        end
    end

    assign state_o    = state_q;
    assign key_held_o = held_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan sequencer: strobes columns, samples rows, forms one result
// per full scan, debounces it and delivers press events over valid/ready.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 100000,
    parameter int unsigned SETTLE_TICKS   = 8,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int unsigned   SW          = $clog2(SCAN_TICKS);
    localparam logic [SW-1:0] SLOT_LAST   = SW'(SCAN_TICKS - 1);
    localparam logic [SW-1:0] SLOT_SAMPLE = SW'(SETTLE_TICKS);

    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    col_q;
    logic [3:0]    row_s1_q, row_s2_q;
    logic          acc_hit_q, acc_hit_d;
    logic          acc_multi_q, acc_multi_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic          valid_q, overrun_q;
    logic [3:0]    code_q;

    logic          sample_en, scan_vld;
    logic [3:0]    row_low, samp_code;
    logic          samp_hit, samp_multi;
    scan_res_t     scan_res;
    db_state_e     db_state;
    logic          db_held, db_event;
    logic [3:0]    db_code;

    always_comb begin
        slot_d    = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
        idx_d     = (slot_q == SLOT_LAST) ? idx_q + 2'd1 : idx_q;
        sample_en = (slot_q == SLOT_SAMPLE);
        scan_vld  = sample_en && (idx_q == 2'd3);

        row_low    = ~row_s2_q;
        samp_hit   = $onehot(row_low);
        samp_multi = !$onehot0(row_low);
        case (row_low)
            4'b1000: samp_code = KEY_MAP[idx_q][0];
            4'b0100: samp_code = KEY_MAP[idx_q][1];
            4'b0010: samp_code = KEY_MAP[idx_q][2];
            4'b0001: samp_code = KEY_MAP[idx_q][3];
            default: samp_code = 4'h0;
        endcase

        // A second hit in a later column makes the whole scan ambiguous.
        acc_hit_d   = acc_hit_q | samp_hit;
        acc_multi_d = acc_multi_q | samp_multi | (acc_hit_q & samp_hit);
        acc_code_d  = samp_hit ? samp_code : acc_code_q;

        scan_res = '{kind: DB_NONE, code: 4'h0};
        if (acc_multi_d)
            scan_res = '{kind: DB_INVALID, code: 4'h0};
        else if (acc_hit_d)
            scan_res = '{kind: DB_KEY, code: acc_code_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            idx_q       <= '0;
            col_q       <= '1;
            row_s1_q    <= '1;
            row_s2_q    <= '1;
            acc_hit_q   <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_code_q  <= '0;
            valid_q     <= 1'b0;
            code_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            idx_q    <= idx_d;
            col_q    <= col_strobe(idx_q);
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
            if (sample_en) begin
                acc_hit_q   <= scan_vld ? 1'b0 : acc_hit_d;
                acc_multi_q <= scan_vld ? 1'b0 : acc_multi_d;
                acc_code_q  <= scan_vld ? 4'h0 : acc_code_d;
            end
            overrun_q <= 1'b0;
            if (db_event) begin
                if (!valid_q || key_ready) begin
                    valid_q <= 1'b1;
                    code_q  <= db_code;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && key_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_vld_i   (scan_vld),
        .scan_res_i   (scan_res),
        .state_o      (db_state),
        .key_held_o   (db_held),
        .event_o      (db_event),
        .event_code_o (db_code)
    );

    assign col       = col_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_held  = db_held && (db_state == DB_KEY);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: an ideal keypad driven from a pressed-key mask,
// compared every cycle against a scan-level debounce/handshake model.
module tb_keypad_scan_ctrl;

    localparam int unsigned SCAN     = 16;
    localparam int unsigned SETTLE   = 4;
    localparam int unsigned DEB      = 2;
    localparam int unsigned SCAN_CYC = 4 * SCAN;
    localparam int unsigned COMMIT_K = 3 * SCAN + SETTLE + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    keypad_scan_ctrl #(
        .SCAN_TICKS    (SCAN),
        .SETTLE_TICKS  (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Pressed keys: bit c*4+r is column C(c+1), row R(r+1).
    logic [15:0] mask;
    int code_of [16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

    always_comb begin
        row = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (mask[c*4+r] && (col[3-c] == 1'b0))
                    row[3-r] = 1'b0;
    end

    int unsigned k;
    int          errors = 0;
    int          checks = 0;
    int          n_xfer, n_ovr;

    // Model: key encoding -1 = none, 16 = invalid, 0..15 = key code.
    int          cand, cnt, committed;
    logic        m_valid, m_ovr;
    logic [3:0]  m_code;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
        end
    endtask

    function automatic int scan_result(input logic [15:0] m);
        int n;
        n = $countones(m);
        if (n == 0) return -1;
        if (n > 1) return 16;
        for (int i = 0; i < 16; i++)
            if (m[i]) return code_of[i];
        return -1;
    endfunction

    task automatic model_reset();
        k         = 0;
        cand      = -1;
        cnt       = 0;
        committed = -1;
        m_valid   = 1'b0;
        m_code    = 4'h0;
        m_ovr     = 1'b0;
    endtask

    task automatic step();
        logic       ev;
        logic [3:0] ev_code;
        int         res;
        int unsigned idx;
        if (key_valid && key_ready) n_xfer++;
        @(posedge clk);
        k++;
        ev      = 1'b0;
        ev_code = 4'h0;
        if (k % SCAN_CYC == COMMIT_K) begin
            res = scan_result(mask);
            if (res == cand) begin
                cnt = (cnt < DEB) ? cnt + 1 : DEB;
            end else begin
                cand = res;
                cnt  = 1;
            end
            if (cnt == DEB) begin
                if (cand >= 0 && cand < 16 && cand != committed) begin
                    ev      = 1'b1;
                    ev_code = 4'(cand);
                end
                committed = cand;
            end
        end
        m_ovr = 1'b0;
        if (ev) begin
            if (!m_valid || key_ready) begin
                m_valid = 1'b1;
                m_code  = ev_code;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && key_ready) begin
            m_valid = 1'b0;
        end
        #1;
        idx = ((k - 1) / SCAN) % 4;
        chk("col", col, ~(4'b1000 >> idx));
        chk("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
        chk("key_code", key_code, m_code);
        chk("key_held", {3'b0, key_held}, {3'b0, (committed >= 0 && committed < 16)});
        chk("overrun", {3'b0, overrun}, {3'b0, m_ovr});
        if (overrun) n_ovr++;
    endtask

    // ready_mode: 0 = never ready, 1 = always ready, 2 = random per cycle
    task automatic run_scans(input logic [15:0] m, input int n, input int ready_mode);
        mask = m;
        for (int s = 0; s < n * int'(SCAN_CYC); s++) begin
            key_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
            step();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_col", col, 4'b1111);
        chk("rst_valid", {3'b0, key_valid}, 4'h0);
        chk("rst_code", key_code, 4'h0);
        chk("rst_held", {3'b0, key_held}, 4'h0);
        chk("rst_overrun", {3'b0, overrun}, 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [15:0] rm;
        int          sel;
        rst_n     = 1'b1;
        mask      = '0;
        key_ready = 1'b0;
        model_reset();
        #1;
        do_reset();

        // No keys: column sequence only, nothing delivered.
        n_xfer = 0;
        run_scans(16'h0000, 2, 1);
        chk("idle_xfers", 4'(n_xfer), 4'd0);

        // "5" held three scans with a ready consumer: exactly one event.
        n_xfer = 0;
        run_scans(16'h0020, 3, 1);
        chk("key5_xfers", 4'(n_xfer), 4'd1);

        // "D" unaccepted, release, then "7": the 7 event is dropped.
        n_ovr = 0;
        run_scans(16'h8000, 3, 0);
        run_scans(16'h0000, 2, 0);
        run_scans(16'h0004, 3, 0);
        chk("d7_overruns", 4'(n_ovr), 4'd1);
        n_xfer = 0;
        run_scans(16'h0004, 1, 1);
        chk("d_drain_xfers", 4'(n_xfer), 4'd1);

        // "1"+"2" together is invalid; releasing "2" yields a 1 event.
        n_xfer = 0;
        run_scans(16'h0011, 4, 1);
        chk("multi_xfers", 4'(n_xfer), 4'd0);
        run_scans(16'h0001, 3, 1);
        chk("key1_xfers", 4'(n_xfer), 4'd1);

        // Bouncing "9" never settles; then it holds and fires once.
        n_xfer = 0;
        for (int b = 0; b < 6; b++)
            run_scans((b % 2 == 0) ? 16'h0400 : 16'h0000, 1, 1);
        chk("bounce_xfers", 4'(n_xfer), 4'd0);
        run_scans(16'h0400, 3, 1);
        chk("key9_xfers", 4'(n_xfer), 4'd1);

        // Pending "3", then reset just before the "A" commit.
        run_scans(16'h0100, 2, 0);
        run_scans(16'h1000, 1, 0);
        for (int s = 0; s < int'(COMMIT_K) - 1; s++) step();
        do_reset();
        n_xfer = 0;
        run_scans(16'h1000, 3, 1);
        chk("post_rst_xfers", 4'(n_xfer), 4'd1);

        // Random press patterns with random consumer readiness.
        for (int seg = 0; seg < 16; seg++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)
                rm = '0;
            else if (sel < 9)
                rm = 16'h0001 << $urandom_range(0, 15);
            else
                rm = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            run_scans(rm, $urandom_range(1, 3), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
